// File: rtl/maxclk_ramp_ctrl.sv
// Hash-PLL frequency ramp scheduler: walks current_freq toward a host target one bounded
// step per clocking-block reconfiguration. Define MAXCLK_LOCKWATCH_EN to add the idle/dwell lock-loss watchdog.
module maxclk_ramp_ctrl #(
    parameter int unsigned STEP        = 8,
    parameter int unsigned FREQ_MAX    = 96,
    parameter int unsigned DWELL_CYC   = 25000,
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       target_valid_i,
    input  logic [7:0] target_freq_i,
    input  logic       host_break_i,
    input  logic       busy_i,
    input  logic       reconfig_ok_i,
    input  logic       lock_h_i,
    output logic       go_reconfig_o,
    output logic [7:0] reqstd_frequency_o,
    output logic [7:0] current_freq_o,
    output logic       ramp_active_o,
    output logic       fault_o,
    output logic [1:0] retry_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        REQ,
        WAIT_BUSY,
        WAIT_DONE,
        DWELL,
        FAULT
    } state_t;

    localparam int unsigned DW_W      = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYC - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYC - 1);
    localparam logic [8:0]  STEP9     = 9'(STEP);
    localparam logic [8:0]  MAX9      = 9'(FREQ_MAX);
    localparam logic [7:0]  MAX8      = 8'(FREQ_MAX);
    localparam logic [1:0]  RETRY_LIM = 2'(MAX_RETRY);

    state_t          state_q, state_d;
    logic [7:0]      target_q, target_d;
    logic [7:0]      current_q, current_d;
    logic [7:0]      req_q, req_d;
    logic            go_q, go_d;
    logic            fault_q, fault_d;
    logic [1:0]      retry_q, retry_d;
    logic [15:0]     toCnt_q, toCnt_d;
    logic [DW_W-1:0] dwellCnt_q, dwellCnt_d;
    logic            breakPrev_q;

    logic [8:0]      tgt9, cur9, diff9, stepAmt9, next9;
    logic [7:0]      nextCode;
    logic            failAttempt;
    logic            breakRise;
    logic            lockLoss;

    function automatic logic [7:0] clampCode(input logic [7:0] code);
        if (code == 8'd0) return 8'd1;
        if ({1'b0, code} > MAX9) return MAX8;
        return code;
    endfunction

    // One bounded step from current toward target, kept inside [1, FREQ_MAX].
    always_comb begin
        tgt9     = {1'b0, target_q};
        cur9     = {1'b0, current_q};
        diff9    = '0;
        stepAmt9 = '0;
        next9    = cur9;
        nextCode = current_q;
        if (tgt9 >= cur9) begin
            diff9    = tgt9 - cur9;
            stepAmt9 = (diff9 > STEP9) ? STEP9 : diff9;
            next9    = cur9 + stepAmt9;
            nextCode = (next9 > MAX9) ? MAX8 : next9[7:0];
        end else begin
            diff9    = cur9 - tgt9;
            stepAmt9 = (diff9 > STEP9) ? STEP9 : diff9;
            next9    = cur9 - stepAmt9;
            nextCode = (next9 < 9'd1 || next9 > MAX9) ? 8'd1 : next9[7:0];
        end
    end

`ifdef MAXCLK_LOCKWATCH_EN
    logic [3:0] lockLow_q, lockLow_d;

    // Sixteen consecutive low lock samples while parked count as a lock loss.
    always_comb begin
        lockLoss  = 1'b0;
        lockLow_d = 4'd0;
        if ((state_q == IDLE || state_q == DWELL) && !lock_h_i) begin
            if (lockLow_q == 4'd15) lockLoss = 1'b1;
            else                    lockLow_d = lockLow_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lockLow_q <= 4'd0;
        else         lockLow_q <= lockLow_d;
    end
`else
    assign lockLoss = 1'b0;
`endif

    assign breakRise = host_break_i & ~breakPrev_q;

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        current_d   = current_q;
        req_d       = req_q;
        go_d        = go_q;
        fault_d     = fault_q;
        retry_d     = retry_q;
        toCnt_d     = toCnt_q;
        dwellCnt_d  = dwellCnt_q;
        failAttempt = 1'b0;

        if (state_q != FAULT) begin
            if (host_break_i)        target_d = 8'd1;
            else if (target_valid_i) target_d = clampCode(target_freq_i);
        end

        case (state_q)
            IDLE: begin
                if (target_q != current_q) state_d = CALC;
            end
            CALC: begin
                req_d   = nextCode;
                state_d = REQ;
            end
            REQ: begin
                go_d    = 1'b1;
                toCnt_d = 16'd0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_i) begin
                    go_d    = 1'b0;
                    toCnt_d = 16'd0;
                    state_d = WAIT_DONE;
                end else if (toCnt_q == TO_LAST) begin
                    failAttempt = 1'b1;
                end else begin
                    toCnt_d = toCnt_q + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (reconfig_ok_i && lock_h_i) begin
                    current_d  = req_q;
                    retry_d    = 2'd0;
                    dwellCnt_d = '0;
                    state_d    = DWELL;
                end else if (!busy_i || toCnt_q == TO_LAST) begin
                    failAttempt = 1'b1;
                end else begin
                    toCnt_d = toCnt_q + 16'd1;
                end
            end
            DWELL: begin
                if (dwellCnt_q == DW_LAST) state_d = IDLE;
                else                       dwellCnt_d = dwellCnt_q + 1'b1;
            end
            FAULT: begin
                go_d = 1'b0;
                if (breakRise) begin
                    fault_d  = 1'b0;
                    retry_d  = 2'd0;
                    target_d = 8'd1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A lock loss reprograms code 1 and is charged like a failed attempt.
        if (lockLoss) begin
            current_d  = 8'd1;
            target_d   = 8'd1;
            dwellCnt_d = '0;
        end

        if (failAttempt || lockLoss) begin
            go_d = 1'b0;
            if (retry_q < RETRY_LIM) begin
                retry_d = retry_q + 2'd1;
                state_d = CALC;
            end else begin
                fault_d = 1'b1;
                state_d = FAULT;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            target_q    <= 8'd1;
            current_q   <= 8'd1;
            req_q       <= 8'd1;
            go_q        <= 1'b0;
            fault_q     <= 1'b0;
            retry_q     <= 2'd0;
            toCnt_q     <= 16'd0;
            dwellCnt_q  <= '0;
            breakPrev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            current_q   <= current_d;
            req_q       <= req_d;
            go_q        <= go_d;
            fault_q     <= fault_d;
            retry_q     <= retry_d;
            toCnt_q     <= toCnt_d;
            dwellCnt_q  <= dwellCnt_d;
            breakPrev_q <= host_break_i;
        end
    end

    assign go_reconfig_o      = go_q;
    assign reqstd_frequency_o = req_q;
    assign current_freq_o     = current_q;
    assign ramp_active_o      = (state_q != IDLE) && (state_q != FAULT);
    assign fault_o            = fault_q;
    assign retry_cnt_o        = retry_q;

endmodule

// File: tb/tb_maxclk_ramp_ctrl.sv
// Directed plus randomized bench for maxclk_ramp_ctrl with a behavioural clocking-block stub
// and an arithmetic model of the expected request sequence.
module tb_maxclk_ramp_ctrl;

    localparam int STEP        = 8;
    localparam int FREQ_MAX    = 96;
    localparam int DWELL_CYC   = 40;
    localparam int TIMEOUT_CYC = 60;
    localparam int MAX_RETRY   = 3;
    localparam int BUDGET      = 5000;

    typedef int codeQ_t[$];

    logic       clk;
    logic       rstN;
    logic       targetValid;
    logic [7:0] targetFreq;
    logic       hostBreak;
    logic       busy;
    logic       reconfigOk;
    logic       lockH;
    logic       goReconfig;
    logic [7:0] reqFreq;
    logic [7:0] currentFreq;
    logic       rampActive;
    logic       faultFlag;
    logic [1:0] retryCnt;

    int assertCount = 0;
    int failCount   = 0;
    int cycleCount  = 0;
    int withhold    = 0;
    int modelCur    = 1;

    int reqCodes[$];
    int reqRetry[$];
    int reqCycle[$];

    maxclk_ramp_ctrl #(
        .STEP(STEP), .FREQ_MAX(FREQ_MAX), .DWELL_CYC(DWELL_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk_i(clk),
        .rst_ni(rstN),
        .target_valid_i(targetValid),
        .target_freq_i(targetFreq),
        .host_break_i(hostBreak),
        .busy_i(busy),
        .reconfig_ok_i(reconfigOk),
        .lock_h_i(lockH),
        .go_reconfig_o(goReconfig),
        .reqstd_frequency_o(reqFreq),
        .current_freq_o(currentFreq),
        .ramp_active_o(rampActive),
        .fault_o(faultFlag),
        .retry_cnt_o(retryCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    function automatic int clampTarget(int t);
        if (t < 1) return 1;
        if (t > FREQ_MAX) return FREQ_MAX;
        return t;
    endfunction

    function automatic codeQ_t rampCodes(int fromCode, int toCode);
        codeQ_t q;
        int c = fromCode;
        while (c != toCode && q.size() < 200) begin
            if (toCode > c) c = (toCode - c > STEP) ? c + STEP : toCode;
            else            c = (c - toCode > STEP) ? c - STEP : toCode;
            q.push_back(c);
        end
        return q;
    endfunction

    function automatic codeQ_t zerosLike(int n);
        codeQ_t q;
        for (int i = 0; i < n; i++) q.push_back(0);
        return q;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] tgt);
        targetValid = 1'b1;
        targetFreq  = tgt;
        @(negedge clk);
        targetValid = 1'b0;
    endtask

    task automatic waitSettled(input string tag);
        int idleRun = 0;
        int n = 0;
        repeat (4) @(negedge clk);
        while (idleRun < 3 && n < BUDGET) begin
            if (!rampActive) idleRun++;
            else             idleRun = 0;
            n++;
            @(negedge clk);
        end
        checkOutput({tag, "_settled"}, 32'(idleRun >= 3), 1);
    endtask

    task automatic checkRequests(input string tag, input codeQ_t expCodes, input codeQ_t expRetries, input int minGap);
        int n;
        checkOutput({tag, "_count"}, reqCodes.size(), expCodes.size());
        n = (reqCodes.size() < expCodes.size()) ? reqCodes.size() : expCodes.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_code%0d", tag, i), reqCodes[i], expCodes[i]);
            checkOutput($sformatf("%s_retry%0d", tag, i), reqRetry[i], expRetries[i]);
            if (i > 0)
                checkOutput($sformatf("%s_gap%0d", tag, i),
                            32'((reqCycle[i] - reqCycle[i-1]) >= minGap), 1);
        end
        reqCodes.delete();
        reqRetry.delete();
        reqCycle.delete();
    endtask

    task automatic checkSteady(input string tag);
        checkOutput({tag, "_cur"},   currentFreq, modelCur);
        checkOutput({tag, "_ramp"},  rampActive, 0);
        checkOutput({tag, "_retry"}, retryCnt, 0);
        checkOutput({tag, "_fault"}, faultFlag, 0);
        checkOutput({tag, "_go"},    goReconfig, 0);
    endtask

    task automatic runRamp(input string tag, input int tgt);
        codeQ_t expCodes;
        expCodes = rampCodes(modelCur, clampTarget(tgt));
        applyStimulus(8'(tgt));
        waitSettled(tag);
        checkRequests(tag, expCodes, zerosLike(expCodes.size()), DWELL_CYC);
        modelCur = clampTarget(tgt);
        checkSteady(tag);
    endtask

    // Clocking-block stub: answers each new go_reconfig unless told to withhold busy.
    initial begin
        bit goSeen = 0;
        int delay;
        int hold;
        busy = 1'b0;
        reconfigOk = 1'b0;
        forever begin
            @(negedge clk);
            if (goReconfig && !goSeen) begin
                goSeen = 1;
                reqCodes.push_back(int'(reqFreq));
                reqRetry.push_back(int'(retryCnt));
                reqCycle.push_back(cycleCount);
                if (withhold > 0) begin
                    withhold--;
                end else begin
                    delay = $urandom_range(3, 6);
                    repeat (delay - 1) @(negedge clk);
                    busy = 1'b1;
                    hold = $urandom_range(1, 4);
                    repeat (hold) @(negedge clk);
                    busy = 1'b0;
                    reconfigOk = 1'b1;
                    @(negedge clk);
                    reconfigOk = 1'b0;
                end
            end
            if (!goReconfig) goSeen = 0;
        end
    end

    initial begin
        codeQ_t expCodes;
        codeQ_t expRetries;
        int n;
        int t;
        rstN        = 1'b0;
        targetValid = 1'b0;
        targetFreq  = 8'd0;
        hostBreak   = 1'b0;
        lockH       = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rst_go",    goReconfig, 0);
        checkOutput("rst_req",   reqFreq, 1);
        checkOutput("rst_cur",   currentFreq, 1);
        checkOutput("rst_ramp",  rampActive, 0);
        checkOutput("rst_fault", faultFlag, 0);
        checkOutput("rst_retry", retryCnt, 0);
        rstN = 1'b1;
        @(negedge clk);

        runRamp("clamp_low", 0);
        runRamp("ramp_up40", 40);
        runRamp("clamp_high", 200);

        // One withheld busy: timeout, then the same code reissued with retry_cnt 1.
        withhold = 1;
        applyStimulus(8'd90);
        waitSettled("retry");
        expCodes = '{90, 90};
        expRetries = '{0, 1};
        checkRequests("retry", expCodes, expRetries, TIMEOUT_CYC);
        modelCur = 90;
        checkSteady("retry_end");

        // Four timeouts in a row exhaust the retry budget.
        withhold = 4;
        applyStimulus(8'd85);
        waitSettled("fault");
        expCodes = '{85, 85, 85, 85};
        expRetries = '{0, 1, 2, 3};
        checkRequests("fault", expCodes, expRetries, TIMEOUT_CYC);
        checkOutput("fault_flag",  faultFlag, 1);
        checkOutput("fault_retry", retryCnt, 3);
        checkOutput("fault_cur",   currentFreq, 90);
        withhold = 0;
        repeat (20) @(negedge clk);
        applyStimulus(8'd50);
        repeat (20) @(negedge clk);
        checkOutput("fault_frozen_reqs", reqCodes.size(), 0);
        checkOutput("fault_frozen_go",   goReconfig, 0);
        checkOutput("fault_sticky",      faultFlag, 1);
        hostBreak = 1'b1;
        @(negedge clk);
        checkOutput("break_fault_clr", faultFlag, 0);
        checkOutput("break_retry_clr", retryCnt, 0);
        hostBreak = 1'b0;
        waitSettled("break_ramp");
        expCodes = rampCodes(90, 1);
        checkRequests("break_ramp", expCodes, zerosLike(expCodes.size()), DWELL_CYC);
        modelCur = 1;
        checkSteady("break_end");

        // Retarget while dwelling at 24 during a climb toward 64.
        runRamp("to16", 16);
        applyStimulus(8'd64);
        n = 0;
        while (currentFreq != 8'd24 && n < BUDGET) begin
            n++;
            @(negedge clk);
        end
        checkOutput("retarget_at24", currentFreq, 24);
        applyStimulus(8'd16);
        waitSettled("retarget");
        expCodes = '{24, 16};
        checkRequests("retarget", expCodes, zerosLike(2), DWELL_CYC);
        modelCur = 16;
        checkSteady("retarget_end");

`ifdef MAXCLK_LOCKWATCH_EN
        lockH = 1'b0;
        repeat (15) @(negedge clk);
        lockH = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("glitch_reqs", reqCodes.size(), 0);
        checkOutput("glitch_cur",  currentFreq, 16);
        lockH = 1'b0;
        repeat (16) @(negedge clk);
        lockH = 1'b1;
        checkOutput("lockloss_cur", currentFreq, 1);
        waitSettled("lockloss");
        expCodes = '{1};
        expRetries = '{1};
        checkRequests("lockloss", expCodes, expRetries, 0);
        modelCur = 1;
        checkSteady("lockloss_end");
`else
        lockH = 1'b0;
        repeat (20) @(negedge clk);
        lockH = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("lockidle_reqs", reqCodes.size(), 0);
        checkOutput("lockidle_cur",  currentFreq, 16);
`endif

        for (int k = 0; k < 6; k++) begin
            t = int'($urandom_range(0, 255));
            runRamp($sformatf("rand%0d", k), t);
        end

        // Reset in the middle of a handshake returns everything to reset values.
        applyStimulus((modelCur == 60) ? 8'd20 : 8'd60);
        n = 0;
        while (!goReconfig && n < BUDGET) begin
            n++;
            @(negedge clk);
        end
        checkOutput("midrst_go_seen", goReconfig, 1);
        rstN = 1'b0;
        #1;
        checkOutput("midrst_go",    goReconfig, 0);
        checkOutput("midrst_req",   reqFreq, 1);
        checkOutput("midrst_cur",   currentFreq, 1);
        checkOutput("midrst_ramp",  rampActive, 0);
        checkOutput("midrst_fault", faultFlag, 0);
        checkOutput("midrst_retry", retryCnt, 0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("postrst_ramp", rampActive, 0);
        checkOutput("postrst_cur",  currentFreq, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/maxclk_ramp_ctrl.md
# maxclk_ramp_ctrl

Frequency ramp scheduler for the reconfigurable hashing PLL. It accepts a target hash-clock code from the host and steps the PLL toward it one bounded increment at a time. Each step is a single reconfiguration request to the clocking block, with handshake supervision, timeout/retry, and a dwell between steps. It sits between host command decode and the clocking block and runs in the 25 MHz UART/scan clock domain.

## Interface
Parameters:
- STEP, 8: maximum code change per reconfiguration.
- FREQ_MAX, 96: highest legal frequency code. Lowest legal code is 1.
- DWELL_CYC, 25000: clk cycles to wait after a successful step before the next step.
- TIMEOUT_CYC, 65535: clk cycles allowed per handshake phase.
- MAX_RETRY, 3: consecutive failed attempts tolerated before FAULT.

Ports:
- clk  in  1  25 MHz domain clock (same clock as the PLL scan clock).
- rst_n  in  1  reset, asynchronous, active-low.
- target_valid  in  1  single-cycle strobe: load target_freq.
- target_freq  in  8  requested code. Clamped to [1, FREQ_MAX] on load.
- host_break  in  1  level: force target to 1.
- busy  in  1  clocking block busy.
- reconfig_ok  in  1  clocking block success flag.
- lock_h  in  1  hashing PLL lock.
- go_reconfig  out  1  level request to the clocking block.
- reqstd_frequency  out  8  code presented with go_reconfig.
- current_freq  out  8  last successfully applied code.
- ramp_active  out  1  high whenever the state is not IDLE or FAULT.
- fault  out  1  sticky failure flag.
- retry_cnt  out  2  failed attempts on the current step.

## Operation
- Target register: loaded on target_valid in any state except FAULT. If host_break is high, the target is held at 1; host_break has priority over target_valid.
- States: IDLE, CALC, REQ, WAIT_BUSY, WAIT_DONE, DWELL, FAULT.
- IDLE: if target != current_freq, go to CALC.
- CALC: next = current ± min(STEP, |target − current|). Arithmetic is 9-bit, and the result never leaves [1, FREQ_MAX]. Drive reqstd_frequency = next, then go to REQ.
- REQ: assert go_reconfig, then go to WAIT_BUSY.
- WAIT_BUSY: on busy=1, deassert go_reconfig and go to WAIT_DONE.
- WAIT_DONE:
  - reconfig_ok=1 and lock_h=1: current_freq ← reqstd_frequency, retry_cnt ← 0, go to DWELL.
  - busy falls without reconfig_ok: attempt failed.
- Timeout: each of WAIT_BUSY and WAIT_DONE uses a 16-bit counter reset on entry. Reaching TIMEOUT_CYC counts as a failed attempt.
- Failed attempt: deassert go_reconfig and increment retry_cnt. If retry_cnt < MAX_RETRY, go to CALC (same next code); otherwise set fault and go to FAULT.
- DWELL: count DWELL_CYC, then go to IDLE. A target change during DWELL takes effect at the following CALC. The step in flight is never aborted.
- FAULT: go_reconfig=0 and requests are frozen. Exit only via a rising edge of host_break: clear fault and retry_cnt, set target to 1, go to IDLE.
- Reset mid-handshake: all state returns to reset values immediately. The clocking block completes its own sequence independently.

## Timing
- Reset values: go_reconfig 0, reqstd_frequency 1, current_freq 1, ramp_active 0, fault 0, retry_cnt 0. Target register resets to 1.
- target_valid sampled at edge N: IDLE→CALC at N+1 if the target differs; go_reconfig high at N+3.
- go_reconfig stays high until the first cycle busy is sampled high; it falls on the next edge. reqstd_frequency is stable from CALC until the next CALC.
- The clocking block double-registers go_reconfig, so busy is expected ≥3 cycles after go_reconfig rises.
- current_freq updates on the edge after reconfig_ok&lock_h is sampled.
- If target_valid and the step-success edge coincide, both take effect: the new target is used at the next CALC.

## Configuration
- MAXCLK_LOCKWATCH_EN defined:
  - In IDLE or DWELL, lock_h low for 16 consecutive cycles counts as a lock loss.
  - On lock loss: current_freq ← 1, target ← 1, retry_cnt increments, go to CALC. This reprograms code 1. Reaching MAX_RETRY sets fault.
- Undefined: lock_h is checked only in WAIT_DONE, and no watchdog logic is synthesized.

## Test plan
- Ramp up: STEP=8, target 40 from reset → requests 9, 17, 25, 33, 40 in order, each ≥DWELL_CYC apart; final current_freq=40, ramp_active=0.
- Clamp: target_freq 0 → target 1, no request issued. target 200 → ramp ends at 96.
- Retry: the model withholds busy for the first attempt → timeout after TIMEOUT_CYC, retry_cnt=1, identical reqstd_frequency reissued; success clears retry_cnt to 0.
- Fault: 4 consecutive timeouts (MAX_RETRY=3) → fault=1, go_reconfig stays 0. host_break rising edge → fault=0, then ramp down to 1.
- Mid-ramp retarget: target 64 while at 24 in DWELL, then target 16 → next request 16, then idle.
- MAXCLK_LOCKWATCH_EN: lock_h dropped for 16 cycles while at 40 → current_freq=1, request for code 1 issued. A 15-cycle glitch → no action.
